// File: rtl/motor_pkg.sv
// Shared drive-code constants and the back-EMF sequencer state type for the
// multi-channel H-bridge driver.
package motor_pkg;

  localparam logic [1:0] DRV_IDLE  = 2'b00;
  localparam logic [1:0] DRV_FWD   = 2'b10;
  localparam logic [1:0] DRV_REV   = 2'b01;
  localparam logic [1:0] DRV_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_COAST  = 2'd1,
    ST_SAMPLE = 2'd2
  } bemf_state_e;

  // A direct forward<->reverse swap needs dead time to avoid shoot-through.
  function automatic logic is_reversal(input logic [1:0] old_code,
                                       input logic [1:0] new_code);
    return ((old_code == DRV_FWD) && (new_code == DRV_REV)) ||
           ((old_code == DRV_REV) && (new_code == DRV_FWD));
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One motor channel: double-buffered duty/code, period compare and
// reversal dead-time counter.
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int DUTY_W     = 12,
  parameter int DEAD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              update,
  input  logic              wrap,
  input  logic              tick,
  input  logic [DUTY_W-1:0] duty,
  input  logic [1:0]        drive_code,
  input  logic [DUTY_W-1:0] cnt,
  output logic              on,
  output logic [1:0]        code
);

  localparam int DEAD_W = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

  logic [DUTY_W-1:0] shadow_duty;
  logic [1:0]        shadow_code;
  logic              pending;
  logic [DUTY_W-1:0] applied_duty;
  logic [1:0]        applied_code;
  logic [DEAD_W-1:0] dead_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_duty  <= '0;
      shadow_code  <= DRV_IDLE;
      pending      <= 1'b0;
      applied_duty <= '0;
      applied_code <= DRV_IDLE;
      dead_cnt     <= '0;
    end else begin
      if (update) begin
        shadow_duty <= duty;
        shadow_code <= drive_code;
      end
      // A wrap consumes the previous capture; an update on that same cycle
      // stays pending for the following wrap.
      if (update)    pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
      if (wrap && pending) begin
        applied_duty <= shadow_duty;
        applied_code <= shadow_code;
      end
      if (wrap && pending && is_reversal(applied_code, shadow_code))
        dead_cnt <= DEAD_W'(DEAD_TICKS);
      else if (tick && (dead_cnt != '0))
        dead_cnt <= dead_cnt - 1'b1;
    end
  end

  assign on   = (cnt < applied_duty) && (dead_cnt == '0);
  assign code = applied_code;

endmodule

// File: rtl/multi_motor_pwm.sv
// N-channel H-bridge driver: shared prescaler/period counter, back-EMF
// coast/sample sequencer and registered, gated bridge outputs.
module multi_motor_pwm
  import motor_pkg::*;
#(
  parameter int NUM_MOT     = 4,
  parameter int DUTY_W      = 12,
  parameter int PRESCALE    = 32,
  parameter int PERIOD      = 2600,
  parameter int DEAD_TICKS  = 4,
  parameter int BEMF_SETTLE = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mot_en,
  input  logic [NUM_MOT*DUTY_W-1:0] duty,
  input  logic [2*NUM_MOT-1:0]      drive_code,
  input  logic                      update,
  input  logic                      bemf_req,
  input  logic                      bemf_done,
  output logic                      pwm,
  output logic [NUM_MOT-1:0]        mtop,
  output logic [NUM_MOT-1:0]        mbot,
  output logic                      period_start,
  output logic                      bemf_busy,
  output logic                      bemf_sample,
  output bemf_state_e               bemf_state
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SET_W = (BEMF_SETTLE > 1) ? $clog2(BEMF_SETTLE) : 1;

  logic [PRE_W-1:0]  pre;
  logic [DUTY_W-1:0] cnt;
  bemf_state_e       state;
  logic              req_pending;
  logic [SET_W-1:0]  settle_cnt;
  logic              tick, run, run_tick, wrap, restart;

  logic [NUM_MOT-1:0] ch_on, top_d, bot_d, act;
  logic [1:0]         ch_code [NUM_MOT];

  assign tick     = (pre == PRE_W'(PRESCALE - 1));
  assign run      = (state == ST_RUN);
  assign run_tick = run && tick;
  assign wrap     = run_tick && (cnt == DUTY_W'(PERIOD - 1));
  assign restart  = (state == ST_SAMPLE) && bemf_done;

  // The prescaler keeps running in COAST so settle ticks can be counted;
  // the period counter is frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      if (restart || tick) pre <= '0;
      else                 pre <= pre + 1'b1;
      if (restart)       cnt <= '0;
      else if (run_tick) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      req_pending <= 1'b0;
      settle_cnt  <= '0;
      bemf_sample <= 1'b0;
    end else begin
      bemf_sample <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bemf_req && !req_pending) req_pending <= 1'b1;
          if (wrap && req_pending) begin
            state       <= ST_COAST;
            req_pending <= 1'b0;
            settle_cnt  <= '0;
          end
        end
        ST_COAST: begin
          if (tick) begin
            if (settle_cnt == SET_W'(BEMF_SETTLE - 1)) begin
              state       <= ST_SAMPLE;
              bemf_sample <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        ST_SAMPLE: if (bemf_done) state <= ST_RUN;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign bemf_busy  = (state != ST_RUN);
  assign bemf_state = state;

  for (genvar i = 0; i < NUM_MOT; i++) begin : g_ch
    motor_pwm_channel #(
      .DUTY_W    (DUTY_W),
      .DEAD_TICKS(DEAD_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .update    (update),
      .wrap      (wrap),
      .tick      (run_tick),
      .duty      (duty[i*DUTY_W +: DUTY_W]),
      .drive_code(drive_code[2*i +: 2]),
      .cnt       (cnt),
      .on        (ch_on[i]),
      .code      (ch_code[i])
    );
  end

  always_comb begin
    top_d = '0;
    bot_d = '0;
    act   = '0;
    for (int i = 0; i < NUM_MOT; i++) begin
      top_d[i] = mot_en && run && ch_on[i] && ch_code[i][1];
      bot_d[i] = mot_en && run && ch_on[i] && ch_code[i][0];
      act[i]   = ch_on[i] && (ch_code[i] != DRV_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtop         <= '0;
      mbot         <= '0;
      pwm          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      mtop         <= top_d;
      mbot         <= bot_d;
      pwm          <= mot_en && run && (|act);
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_multi_motor_pwm.sv
// Directed bench for multi_motor_pwm: 2 channels, PRESCALE=1, PERIOD=10,
// DEAD_TICKS=4, BEMF_SETTLE=8; expected patterns are hand-derived.
module tb_multi_motor_pwm;

  localparam int NM = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mot_en = 1'b1;
  logic [NM*DW-1:0] duty = '0;
  logic [2*NM-1:0] drive_code = '0;
  logic            update = 1'b0;
  logic            bemf_req = 1'b0;
  logic            bemf_done = 1'b0;
  logic            pwm, period_start, bemf_busy, bemf_sample;
  logic [NM-1:0]   mtop, mbot;
  logic [1:0]      bemf_state;

  int checks = 0;
  int errors = 0;

  multi_motor_pwm #(
    .NUM_MOT(NM), .DUTY_W(DW), .PRESCALE(1), .PERIOD(10),
    .DEAD_TICKS(4), .BEMF_SETTLE(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mot_en(mot_en), .duty(duty),
    .drive_code(drive_code), .update(update), .bemf_req(bemf_req),
    .bemf_done(bemf_done), .pwm(pwm), .mtop(mtop), .mbot(mbot),
    .period_start(period_start), .bemf_busy(bemf_busy),
    .bemf_sample(bemf_sample), .bemf_state(bemf_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int d, input logic [1:0] c);
    duty[ch*DW +: DW]     = d[DW-1:0];
    drive_code[2*ch +: 2] = c;
  endtask

  // Returns at the negedge where period_start is high (cnt just wrapped).
  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 40);
    check("ps_seen", {31'd0, period_start}, 32'd1);
  endtask

  task automatic apply_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_ps();
  endtask

  // Bit m-1 holds the value seen m cycles after the period_start cycle.
  task automatic sample_period(output logic [9:0] t0, output logic [9:0] b0,
                               output logic [9:0] t1, output logic [9:0] pw,
                               output logic [9:0] ps);
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      t0[m] = mtop[0];
      b0[m] = mbot[0];
      t1[m] = mtop[1] | mbot[1];
      pw[m] = pwm;
      ps[m] = period_start;
    end
  endtask

  logic [9:0] t0, b0, t1, pw, ps;
  int         n, hits;
  logic       any_out, any_ps;

  initial begin
    #12;
    check("reset_outs", {pwm, mtop, mbot, period_start, bemf_busy, bemf_sample}, 0);
    check("reset_state", bemf_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps();

    // Channel 0 forward at duty 3, channel 1 idle.
    set_ch(0, 3, 2'b10);
    set_ch(1, 0, 2'b00);
    apply_update();
    sample_period(t0, b0, t1, pw, ps);
    check("d3_mtop", t0, 10'b0000000111);
    check("d3_mbot", b0, 10'b0);
    check("d3_pwm", pw, 10'b0000000111);
    check("d3_ps", ps, 10'b1000000000);
    check("d3_ch1", t1, 10'b0);
    sample_period(t0, b0, t1, pw, ps);
    check("d3_mtop_rep", t0, 10'b0000000111);

    set_ch(0, 0, 2'b10);
    apply_update();
    sample_period(t0, b0, t1, pw, ps);
    check("d0_mtop", t0, 10'b0);
    check("d0_pwm", pw, 10'b0);

    set_ch(0, 15, 2'b10);
    set_ch(1, 5, 2'b00);
    apply_update();
    sample_period(t0, b0, t1, pw, ps);
    check("d15_mtop", t0, 10'h3ff);
    check("d15_pwm", pw, 10'h3ff);
    check("d15_ch1_idle", t1, 10'b0);

    // Forward to reverse: four dead ticks after the applying wrap.
    set_ch(0, 15, 2'b01);
    apply_update();
    check("rev_old_code", {31'd0, mtop[0]}, 32'd1);
    sample_period(t0, b0, t1, pw, ps);
    check("rev_mbot", b0, 10'b1111110000);
    check("rev_mtop", t0, 10'b0);
    check("rev_pwm", pw, 10'b1111110000);
    sample_period(t0, b0, t1, pw, ps);
    check("rev_mbot_steady", b0, 10'h3ff);

    set_ch(0, 15, 2'b00);
    set_ch(1, 15, 2'b00);
    apply_update();
    sample_period(t0, b0, t1, pw, ps);
    check("idle_pwm", pw, 10'b0);
    check("idle_outs", t0 | b0 | t1, 10'b0);

    // Update landing on the wrap cycle is applied one period later.
    set_ch(0, 3, 2'b10);
    apply_update();
    for (int m = 0; m < 9; m++) @(negedge clk);
    set_ch(0, 7, 2'b10);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    check("wrapupd_ps", {31'd0, period_start}, 32'd1);
    sample_period(t0, b0, t1, pw, ps);
    check("wrapupd_old", t0, 10'b0000000111);
    sample_period(t0, b0, t1, pw, ps);
    check("wrapupd_new", t0, 10'b0001111111);

    mot_en = 1'b0;
    sample_period(t0, b0, t1, pw, ps);
    check("en0_outs", t0 | b0 | pw, 10'b0);
    check("en0_ps", ps, 10'b1000000000);
    mot_en = 1'b1;

    bemf_done = 1'b1;
    sample_period(t0, b0, t1, pw, ps);
    check("done_in_run_mtop", t0, 10'b0001111111);
    check("done_in_run_ps", ps, 10'b1000000000);
    bemf_done = 1'b0;

    // Back-EMF measurement requested mid-period; a second request is ignored.
    repeat (3) @(negedge clk);
    bemf_req = 1'b1;
    @(negedge clk);
    bemf_req = 1'b0;
    @(negedge clk);
    bemf_req = 1'b1;
    @(negedge clk);
    bemf_req = 1'b0;
    n = 0;
    while (!bemf_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", {31'd0, bemf_busy}, 32'd1);
    check("busy_at_wrap", {31'd0, period_start}, 32'd1);
    n = 0;
    any_out = 1'b0;
    any_ps = 1'b0;
    while (!bemf_sample && n < 40) begin
      @(negedge clk);
      n++;
      any_out |= pwm | (|mtop) | (|mbot);
      any_ps  |= period_start;
    end
    check("settle_cycles", n, 8);
    check("coast_outs", {31'd0, any_out}, 0);
    check("coast_frozen", {31'd0, any_ps}, 0);
    check("sample_state", bemf_state, 2);
    hits = 1;
    bemf_req = 1'b1;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      bemf_req = 1'b0;
      if (bemf_sample) hits++;
    end
    check("sample_pulse", hits, 1);
    check("sample_hold", {31'd0, bemf_busy}, 32'd1);
    bemf_done = 1'b1;
    @(negedge clk);
    bemf_done = 1'b0;
    check("resume_busy", {31'd0, bemf_busy}, 0);
    check("resume_state", bemf_state, 0);
    sample_period(t0, b0, t1, pw, ps);
    check("resume_mtop", t0, 10'b0001111111);
    check("resume_ps", ps, 10'b1000000000);
    check("no_stale_req", {31'd0, bemf_busy}, 0);

    // Asynchronous reset in the middle of COAST.
    bemf_req = 1'b1;
    @(negedge clk);
    bemf_req = 1'b0;
    n = 0;
    while (!bemf_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen2", {31'd0, bemf_busy}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {pwm, mtop, mbot, period_start, bemf_busy, bemf_sample}, 0);
    check("arst_state", bemf_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps();
    sample_period(t0, b0, t1, pw, ps);
    check("post_rst_outs", t0 | b0 | t1 | pw, 10'b0);
    check("post_rst_ps", ps, 10'b1000000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
